apb_slave_mem: RTL and testbench
================================

// Module: apb_slave_mem
// PURPOSE
// - APB3 completer that sits directly downstream of the bridge's APB master; one instance per psel bit
//   (psel[0] -> window 0x0001_F000, psel[1] -> window 0x0002_F000).
// - Word-addressed register/memory bank with programmable wait states and PSLVERR on bad accesses.
// - Serves as the system-level target for bridge read/write bursts and as the bench's APB endpoint.
// PARAMETERS
// - ADDR_WIDTH   32            APB address width
// - DATA_WIDTH   32            APB data width; word = DATA_WIDTH/8 bytes
// - BASE_ADDR    32'h0001_F000 first byte address of this slave's window
// - DEPTH        256           number of DATA_WIDTH words implemented (offsets 0 .. DEPTH*4-1)
// - WAIT_STATES  2             fixed wait states inserted before PREADY (0 = zero-wait)
// PORTS
// - clk      in   1           clock
// - rst_n    in   1           async active-low reset
// - psel     in   1           select (one bit of master psel bus)
// - penable  in   1           access phase
// - pwrite   in   1           1 = write, 0 = read
// - paddr    in   ADDR_WIDTH  byte address
// - pwdata   in   DATA_WIDTH  write data
// - prdata   out  DATA_WIDTH  read data, valid only when pready & !pwrite & !pslverr, else 0
// - pready   out  1           transfer complete
// - pslverr  out  1           error response, valid only with pready
// BEHAVIOUR
// - Single clock; reset is asynchronous and active-low.
// - Reset: FSM=IDLE, pready=0, pslverr=0, prdata=0, wait counter=0, all DEPTH words = 0.
// - FSM IDLE: pready=0; psel & !penable (setup) -> capture paddr/pwrite/pwdata, load counter=WAIT_STATES, goto ACCESS.
// - IDLE with penable=1 and no prior setup: ignored, stays IDLE.
// - ACCESS: counter!=0 -> pready=0, counter-1. counter==0 -> pready=1 (combinational), pslverr/prdata valid,
//   write committed at that clock edge if no error, goto IDLE.
// - Latency: pready in access cycle WAIT_STATES+1; zero-wait transfer = 2 cycles (setup + access).
// - Back-to-back: master holding psel with penable low after completion is a new setup; IDLE accepts it the same cycle.
// - Error (pslverr=1, write suppressed, prdata=0): offset = paddr-BASE_ADDR >= DEPTH*4, paddr < BASE_ADDR, or paddr[1:0]!=0.
// - Index = offset[clog2(DEPTH)+1:2]; no wrap-around, out-of-range never aliases.
// - Abort: psel low while in ACCESS -> IDLE next cycle, no write, pready stays 0.
// - Captured address/control used for decode; changes on paddr/pwrite during ACCESS are ignored.
// - Reset mid-transfer: immediate IDLE, pready/pslverr drop asynchronously, pending write discarded.
// - Counter width = max(1, clog2(WAIT_STATES+1)).
// CONFIGURATION
// - APB_SLV_RAND_WAIT_EN defined: wait states per transfer = lfsr % (WAIT_STATES+1).
//   8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advances once per accepted setup.
// - APB_SLV_RAND_WAIT_EN undefined: fixed WAIT_STATES every transfer; no LFSR logic present.
// TESTING
// - WAIT_STATES=0: write 0xDEADBEEF @0x1F010, then read @0x1F010 -> pready in 1st access cycle,
//   prdata=0xDEADBEEF, pslverr=0.
// - WAIT_STATES=2: read @0x1F000 after reset -> pready low 2 access cycles, high on 3rd, prdata=0.
// - Write 0x12345678 @0x1F400 (DEPTH=256) and @0x1F002 -> pslverr=1 with pready;
//   read @0x1F000 still 0, no aliasing.
// - 4-beat burst: writes 0x1F000..0x1F00C data 1..4, psel held between beats -> 4 completions,
//   read-back 1,2,3,4.
// - rst_n low during 2nd wait cycle of write 0xA5A5A5A5 @0x1F020 -> pready=0 at once,
//   FSM IDLE, read-back @0x1F020 = 0.
// - Abort: psel dropped during wait of write 0xFFFF0000 @0x1F030 -> no pready, read-back = 0;
//   with APB_SLV_RAND_WAIT_EN, 100 reads each complete within WAIT_STATES+1 access cycles.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB3 completer: word-addressed memory window with fixed or pseudo-random wait states and PSLVERR decode.
// Optional: define APB_SLV_RAND_WAIT_EN to draw per-transfer wait states from an 8-bit LFSR.
module apb_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0001_F000,
  parameter int                    DEPTH       = 256,
  parameter int                    WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * 4);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]         cnt, wait_ld;
  logic [ADDR_WIDTH-1:0] addr_q, offset;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q, addr_err, done, setup;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef APB_SLV_RAND_WAIT_EN
  logic [7:0] lfsr;
  assign wait_ld = CW'(({24'd0, lfsr}) % (WAIT_STATES + 1));

  // x^8+x^6+x^5+x^4+1, stepped once per accepted setup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                lfsr <= 8'hA5;
    else if (state == IDLE && setup)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign wait_ld = CW'(WAIT_STATES);
`endif

  assign setup    = psel && !penable;
  assign offset   = addr_q - BASE_ADDR;
  // Below-base, past-end and misaligned addresses all error; nothing aliases back into the array.
  assign addr_err = (addr_q < BASE_ADDR) || (offset >= SPAN) || (addr_q[1:0] != 2'b00);
  assign idx      = offset[IDX_W+1:2];
  assign done     = (state == ACCESS) && psel && (cnt == '0);

  assign pready  = done;
  assign pslverr = done && addr_err;
  assign prdata  = (done && !wr_q && !addr_err) ? mem[idx] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS:  if (!psel || cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && setup) begin
        addr_q  <= paddr;
        wr_q    <= pwrite;
        wdata_q <= pwdata;
        cnt     <= wait_ld;
      end else if (state == ACCESS && psel && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done && wr_q && !addr_err) mem[idx] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: scoreboard of expected completions, reference memory model, immediate asserts.
module tb_apb_slave_mem;
  localparam int          WS   = 2;
  localparam logic [31:0] BASE = 32'h0001_F000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .DEPTH(256), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [int unsigned];
  int          checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a < BASE) || ((a - BASE) >= 32'd1024) || (a[1:0] != 2'b00);
  endfunction

  // Starts at posedge+#1, ends at posedge+#1 with the bus idle (or holding psel for a back-to-back beat).
  task automatic xfer(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d, input bit hold);
    exp_t        e;
    int          waits;
    bit          ok;
    int unsigned k;
    k     = (a - BASE) >> 2;
    e.tag = tag;
    e.err = is_err(a);
    e.data = (wr || e.err) ? 32'h0 : (mdl.exists(k) ? mdl[k] : 32'h0);
    if (wr && !e.err) mdl[k] = d;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    waits = 0; ok = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (pready) begin ok = 1'b1; break; end
      waits++;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 32'(ok), 32'd1);
    e = sb.pop_front();
    if (ok) begin
      check({e.tag, "_rdata"}, prdata, e.data);
      check({e.tag, "_slverr"}, 32'(pslverr), 32'(e.err));
`ifdef APB_SLV_RAND_WAIT_EN
      check({e.tag, "_waits_le"}, 32'(waits <= WS), 32'd1);
`else
      check({e.tag, "_waits"}, 32'(waits), 32'(WS));
`endif
    end
    @(posedge clk); #1 penable = 1'b0; psel = hold;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mdl.delete();
    #1;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    do_reset();
    @(posedge clk); #1;

    xfer("rd_base_init", 1'b0, 32'h0001_F000, 32'h0, 1'b0);
    xfer("wr_deadbeef", 1'b1, 32'h0001_F010, 32'hDEAD_BEEF, 1'b0);
    xfer("rd_deadbeef", 1'b0, 32'h0001_F010, 32'h0, 1'b0);

    xfer("wr_past_end", 1'b1, 32'h0001_F400, 32'h1234_5678, 1'b0);
    xfer("wr_misalign", 1'b1, 32'h0001_F002, 32'h1234_5678, 1'b0);
    xfer("rd_below_base", 1'b0, 32'h0001_EFFC, 32'h0, 1'b0);
    xfer("rd_base_noalias", 1'b0, 32'h0001_F000, 32'h0, 1'b0);
    xfer("wr_last_word", 1'b1, 32'h0001_F3FC, 32'hCAFE_0001, 1'b0);
    xfer("rd_last_word", 1'b0, 32'h0001_F3FC, 32'h0, 1'b0);

    for (int i = 0; i < 4; i++)
      xfer($sformatf("burst_wr%0d", i), 1'b1, BASE + 32'(4 * i), 32'(i + 1), i != 3);
    for (int i = 0; i < 4; i++)
      xfer($sformatf("burst_rd%0d", i), 1'b0, BASE + 32'(4 * i), 32'h0, 1'b0);

    // Abort: psel withdrawn while the write is still waiting
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0001_F030; pwdata = 32'hFFFF_0000;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    check("abort_wait_pready", 32'(pready), 32'd0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_pready", 32'(pready), 32'd0);
    end
    @(posedge clk); #1;
    xfer("rd_after_abort", 1'b0, 32'h0001_F030, 32'h0, 1'b0);

`ifndef APB_SLV_RAND_WAIT_EN
    // Reset during the second wait cycle of a write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0001_F020; pwdata = 32'hA5A5_A5A5;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    do_reset();
    @(posedge clk); #1;
    xfer("rd_after_rst_wait", 1'b0, 32'h0001_F020, 32'h0, 1'b0);
`endif

    // Reset while pready is high: completion drops at once and the write is lost
    xfer("wr_pre_rst", 1'b1, 32'h0001_F028, 32'h0000_5A5A, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0001_F024; pwdata = 32'h1111_2222;
    @(posedge clk); #1 penable = 1'b1;
    begin : wait_rdy
      bit seen;
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (pready) begin seen = 1'b1; break; end
        @(posedge clk); #1;
      end
      check("rst_at_ready_seen", 32'(seen), 32'd1);
    end
    do_reset();
    @(posedge clk); #1;
    xfer("rd_lost_write", 1'b0, 32'h0001_F024, 32'h0, 1'b0);
    xfer("rd_cleared_old", 1'b0, 32'h0001_F028, 32'h0, 1'b0);
    xfer("rd_cleared_db", 1'b0, 32'h0001_F010, 32'h0, 1'b0);

`ifdef APB_SLV_RAND_WAIT_EN
    for (int i = 0; i < 100; i++)
      xfer($sformatf("rand_rd%0d", i), 1'b0, BASE + 32'(4 * $urandom_range(0, 255)), 32'h0, 1'b0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
